reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single write path of a bank of 2^ADDR_W Register instances (IN/Load/OUT, DATA_W bits) among NUM_REQ requesters, e.g. ALU writeback, memory load, PC link and debug.
- Round-robin arbitration over a req/ack handshake; drives the bank's shared IN bus and a one-hot Load vector.
- Also sequences a bank-clear operation that writes zero to every register, one per cycle.

Parameters:
- DATA_W, 32, width of each register and of the write data.
- ADDR_W, 3, register address width; bank size is 2^ADDR_W.
- NUM_REQ, 4, number of requesters. Power of two, at least 2. IDW = clog2(NUM_REQ).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  NUM_REQ  write request per requester.
- WrAddr  in  NUM_REQ*ADDR_W  packed target addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- WrData  in  NUM_REQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- ClearReq  in  1  request a zero-fill of the whole bank.
- Ack  out  NUM_REQ  one-cycle grant/complete pulse per requester.
- GrantId  out  IDW  index of the requester currently granted.
- RegLoad  out  2^ADDR_W  one-hot Load to the register bank.
- RegIn  out  DATA_W  shared IN bus to the register bank.
- Busy  out  1  high in GRANT or CLEAR.
- ClearDone  out  1  one-cycle pulse on the last clear write.

Behaviour:
- All outputs are registered.
- Reset low (async) forces:
  - state = IDLE
  - RegLoad = 0, RegIn = 0, Ack = 0, GrantId = 0, Busy = 0, ClearDone = 0
  - round-robin pointer Ptr = 0, clear counter Cnt = 0
- Reset taken mid-GRANT or mid-CLEAR abandons the operation. No Load pulse may appear after Reset falls.
- Requester contract:
  - Hold Req[i], plus stable WrAddr/WrData slices, until Ack[i] is seen.
  - In the Ack cycle the requester may drop Req or present new data for a further write.
- State IDLE (RegLoad = 0, Busy = 0):
  - If ClearReq: go to CLEAR, Cnt = 0. ClearReq has priority over all Req.
  - Else if Req != 0: the winner is the first set Req at or after Ptr, searching cyclically upward. Latch the winner's address, data and index, then go to GRANT.
  - Else stay in IDLE.
- State GRANT (one cycle):
  - RegLoad = one-hot(latched address), RegIn = latched data.
  - Ack[winner] = 1, GrantId = winner, Busy = 1.
  - Ptr <= (winner + 1) mod NUM_REQ.
  - Next state is IDLE unconditionally. Req and ClearReq are ignored in this cycle.
- State CLEAR:
  - RegLoad = one-hot(Cnt), RegIn = 0, Busy = 1. Cnt increments each cycle.
  - On Cnt = 2^ADDR_W - 1: ClearDone = 1, next state IDLE, Cnt wraps to 0.
  - Req is ignored while in CLEAR and is served after it.
- Latency:
  - Req sampled high in IDLE at edge k gives Load/Ack during cycle k..k+1; the register captures at edge k+1.
  - Peak throughput is one write per 2 cycles.
  - A clear takes exactly 2^ADDR_W cycles of Busy.
- Boundary rules:
  - At most one RegLoad bit is high in any cycle.
  - RegLoad and Ack are never high outside GRANT or CLEAR.
  - Ptr wraps from NUM_REQ-1 to 0.
  - A requester that keeps Req high continuously is served at most once per NUM_REQ grants while others are requesting.
  - ClearReq held high across the end of a clear starts a new clear after one IDLE cycle.

Test Plan:
- Reset low with Req = 4'b1111 -> RegLoad = 0, Ack = 0, Busy = 0. Release reset: first grant goes to requester 0, which has addr 3 and data 32'hA5A5_0001; RegLoad = 8'b0000_1000, RegIn = 32'hA5A5_0001, Ack = 4'b0001, and Register 3 OUT = 32'hA5A5_0001 after the next edge.
- Req = 4'b1111 held for 8 grants -> GrantId sequence 0,1,2,3,0,1,2,3. Ack pulses never adjacent, one grant every 2 cycles.
- Ptr = 2 with Req = 4'b0011 -> requester 0 is granted (cyclic search wraps), and Ptr becomes 1.
- ClearReq and Req[1] asserted together in IDLE -> RegLoad walks 8'h01 to 8'h80 over 8 cycles with RegIn = 0. ClearDone pulses with RegLoad = 8'h80. Requester 1 is acked 2 cycles later.
- Reset asserted during clear cycle 4 -> RegLoad drops to 0 immediately (async), registers 4..7 keep their old values, and state is IDLE after release.
- Requester 2 keeps Req high and changes data from 32'h11 to 32'h22 in its Ack cycle -> two separate grants load 32'h11 then 32'h22, with no duplicate Load of 32'h11.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side and register-bank-side bus of the write arbiter
interface reg_write_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] wr_addr;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic                      clear_req;
  logic [NUM_REQ-1:0]        ack;
  logic [IDW-1:0]            grant_id;
  logic [2**ADDR_W-1:0]      reg_load;
  logic [DATA_W-1:0]         reg_in;
  logic                      busy;
  logic                      clear_done;
  modport master (
    output req, wr_addr, wr_data, clear_req,
    input  ack, grant_id, reg_load, reg_in, busy, clear_done
  );
  modport slave (
    input  req, wr_addr, wr_data, clear_req,
    output ack, grant_id, reg_load, reg_in, busy, clear_done
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin owner of a register bank's single write port, plus bank clear
module reg_write_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int NUM_REQ = 4
) (
  input logic                clk,
  input logic                rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int NREG = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;
  state_t            state_q;
  logic [IDW-1:0]    ptr_q, gid_q, win, idx;
  logic              found;
  logic [ADDR_W-1:0] cnt_q;
  logic [NREG-1:0]   load_q;
  logic [DATA_W-1:0] in_q;
  logic [NUM_REQ-1:0] ack_q;
  logic              busy_q, done_q;
  // first set request at or after ptr_q; walking offsets downward lets the smallest offset win
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_q + IDW'(k);
      if (bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  // control FSM; every bank-facing output is registered so it is valid for the whole cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
      in_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clear_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            load_q  <= NREG'(1);
            in_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= (NREG == 1);
          end else if (found) begin
            state_q <= GRANT;
            load_q  <= NREG'(1) << bus.wr_addr[win*ADDR_W +: ADDR_W];
            in_q    <= bus.wr_data[win*DATA_W +: DATA_W];
            ack_q   <= NUM_REQ'(1) << win;
            gid_q   <= win;
            ptr_q   <= win + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          state_q <= IDLE;
          load_q  <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
        end
        CLEAR: begin
          if (cnt_q == ADDR_W'(NREG - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            load_q <= load_q << 1;
            done_q <= (cnt_q == ADDR_W'(NREG - 2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.reg_load   = load_q;
  assign bus.reg_in     = in_q;
  assign bus.ack        = ack_q;
  assign bus.grant_id   = gid_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = done_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench with a transaction-level arbitration model
module tb_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0, miscompares = 0;
  int cyc = 0, mptr = 0, mbusy = 0, n11 = 0;
  int p_start = 0, p_keep = 0, p_clr = 0;
  bit auto_on = 0, collect = 0;
  logic [31:0] bank [8];
  logic [31:0] mbank [8];
  int gseq [$];
  typedef struct {
    int cyc; int addr; logic [7:0] load; logic [31:0] data; logic [3:0] ack; int gid; bit done;
  } exp_t;
  exp_t q [$];

  reg_write_arbiter_if #(.DATA_W(32), .ADDR_W(3), .NUM_REQ(4)) bus ();
  reg_write_arbiter #(.DATA_W(32), .ADDR_W(3), .NUM_REQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input logic [31:0] d);
    bus.req[i] = 1'b1;
    bus.wr_addr[i*3 +: 3] = 3'(a);
    bus.wr_data[i*32 +: 32] = d;
  endtask

  task automatic wait_ack(input int i);
    bit ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #2;
      if (bus.ack[i]) begin ok = 1; break; end
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) if (bus.req[i] && bus.ack[i]) bus.req[i] = 1'b0;
      if (bus.req == 0 && !bus.busy) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  // register bank the arbiter writes into
  initial begin
    for (int j = 0; j < 8; j++) begin bank[j] = 0; mbank[j] = 0; end
    forever begin
      @(posedge clk);
      for (int j = 0; j < 8; j++) if (bus.reg_load[j]) bank[j] = bus.reg_in;
    end
  end

  // reference model: when free, ClearReq beats requests; winner is first requester cyclically from ptr
  initial forever begin
    int w, a;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mptr = 0; mbusy = 0; q.delete();
    end else begin
      cyc++;
      if (mbusy > 0) mbusy--;
      else if (bus.clear_req) begin
        for (int j = 0; j < 8; j++) q.push_back('{cyc + j, j, 8'(1 << j), 32'h0, 4'h0, 0, (j == 7)});
        mbusy = 8;
      end else if (bus.req != 0) begin
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && bus.req[(mptr + k) % 4]) w = (mptr + k) % 4;
        a = int'(bus.wr_addr[w*3 +: 3]);
        q.push_back('{cyc, a, 8'(1 << a), bus.wr_data[w*32 +: 32], 4'(1 << w), w, 1'b0});
        mptr = (w + 1) % 4;
        mbusy = 1;
      end
    end
  end

  // monitor: every cycle outputs either match the due expected write or are idle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (bus.reg_load != 0 && bus.reg_in == 32'h11) n11++;
      if (collect && bus.ack != 0) gseq.push_back(int'(bus.grant_id));
      if (q.size() != 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("reg_load", bus.reg_load, e.load);
        chk("reg_in", bus.reg_in, e.data);
        chk("ack", bus.ack, e.ack);
        chk("busy", bus.busy, 1);
        chk("clear_done", bus.clear_done, e.done);
        if (e.ack != 0) chk("grant_id", bus.grant_id, e.gid);
        mbank[e.addr] = e.data;
      end else
        chk("idle_outputs", {bus.reg_load, bus.ack, bus.busy, bus.clear_done}, 0);
    end
  end

  // random requester agents honouring the hold-until-ack contract
  initial forever begin
    @(posedge clk); #2;
    if (auto_on) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req[i] && bus.ack[i]) begin
          if ($urandom_range(99) < p_keep) set_req(i, $urandom_range(7), $urandom);
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(99) < p_start)
          set_req(i, $urandom_range(7), $urandom);
      end
      bus.clear_req = ($urandom_range(99) < p_clr);
    end
  end

  initial begin
    int n;
    bit ok;
    bus.req = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.clear_req = 1'b0;
    #3 rst_n = 1'b0;
    set_req(0, 3, 32'hA5A5_0001);
    set_req(1, 0, 32'hB0B0_0001);
    set_req(2, 1, 32'hC0C0_0001);
    set_req(3, 2, 32'hD0D0_0001);
    #20;
    chk("rst_reg_load", bus.reg_load, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    p_keep = 100; p_start = 0; p_clr = 0; collect = 1;
    @(negedge clk); #2 rst_n = 1'b1; auto_on = 1;
    ok = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ack != 0) begin ok = 1; break; end
    end
    chk("first_grant_seen", ok, 1);
    chk("first_load", bus.reg_load, 8'b0000_1000);
    chk("first_in", bus.reg_in, 32'hA5A5_0001);
    chk("first_ack", bus.ack, 4'b0001);
    @(posedge clk); #1;
    chk("reg3_out", bank[3], 32'hA5A5_0001);
    for (n = 0; n < 100 && gseq.size() < 8; n++) @(posedge clk);
    chk("gseq_len", gseq.size() >= 8, 1);
    for (int i = 0; i < 8 && i < gseq.size(); i++) chk("rr_order", gseq[i], i % 4);
    collect = 0;
    @(posedge clk); #2 auto_on = 0;
    drain();
    // pointer wrap: grant 1 leaves ptr at 2, then {0,1} must pick 0
    @(posedge clk); #2 set_req(1, 4, 32'h0000_1111);
    wait_ack(1); bus.req[1] = 1'b0;
    set_req(0, 6, 32'h0000_2222); set_req(1, 7, 32'h0000_3333);
    ok = 0;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #2;
      if (bus.ack != 0) begin ok = 1; break; end
    end
    chk("wrap_seen", ok, 1);
    chk("wrap_winner", bus.ack, 4'b0001);
    bus.req[0] = 1'b0;
    wait_ack(1); bus.req[1] = 1'b0;
    // clear has priority over a simultaneous request
    @(posedge clk); #2 bus.clear_req = 1'b1; set_req(1, 2, 32'h0000_4444);
    @(posedge clk); #2 bus.clear_req = 1'b0;
    ok = 0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.clear_done) begin ok = 1; break; end
    end
    chk("clear_done_seen", ok, 1);
    chk("clear_done_load", bus.reg_load, 8'h80);
    for (n = 1; n < 10; n++) begin
      @(negedge clk);
      if (bus.ack[1]) break;
    end
    chk("ack_after_clear", n, 2);
    @(posedge clk); #2 bus.req[1] = 1'b0;
    // async reset in the middle of a clear
    @(posedge clk); #2 bus.clear_req = 1'b1;
    @(posedge clk); #2 bus.clear_req = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.reg_load == 8'h08) break;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midclear_rst_load", bus.reg_load, 0);
    chk("midclear_rst_busy", bus.busy, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("idle_after_rst", bus.busy, 0);
    // back-to-back writes from one requester without a duplicate load
    @(posedge clk); #2 n11 = 0; set_req(2, 5, 32'h11);
    wait_ack(2); bus.wr_data[2*32 +: 32] = 32'h22;
    wait_ack(2); bus.req[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_dup_load", n11, 1);
    chk("reg5_out", bank[5], 32'h22);
    // randomized traffic
    p_start = 30; p_keep = 50; p_clr = 3;
    @(posedge clk); #2 auto_on = 1;
    repeat (3000) @(posedge clk);
    #2 auto_on = 0; bus.clear_req = 1'b0;
    drain();
    repeat (12) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    for (int j = 0; j < 8; j++) chk("bank_final", bank[j], mbank[j]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
